keypad_hex: RTL and testbench

Scanner for a 4x4 matrix hex keypad. It is the input-side counterpart of the multiplexed 7-segment hex display driver. It drives keypad rows one at a time, active-low, and samples the active-low columns. It debounces over whole scans, emits a one-cycle strobe per new key press, and shifts each entered nibble into a 16-bit value that the top level can route straight to the display driver.

---
 rtl/keypad_hex.sv | 112 +++++++++++
 tb/tb_keypad_hex.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex.sv
// 4x4 hex keypad scanner: active-low row drive, synchronized column sense,
// whole-scan debounce, one-cycle press strobe and a 16-bit nibble entry register.
module keypad_hex #(
  parameter int unsigned DIV_BITS       = 12,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        mclk,
  input  logic        reset,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] value
);

  localparam int unsigned DW      = DIV_BITS + 2;
  localparam logic [3:0]  CNT_MAX = 4'(DEBOUNCE_SCANS);
  localparam logic [4:0]  NONE    = 5'h10;

  logic [DW-1:0] r_div;
  logic [3:0]    r_sync1, r_sync2;
  logic [15:0]   r_snap;
  logic [4:0]    r_prev, r_stable;
  logic [3:0]    r_cnt;

  logic [1:0]    w_row;
  logic          w_sample, w_scan_end, w_accept;
  logic [3:0]    w_cols;
  logic [15:0]   w_snap;
  logic [4:0]    w_pop, w_cand;
  logic [3:0]    w_idx, w_cnt_nxt;

  assign w_row      = r_div[DW-1 -: 2];
  assign w_sample   = &r_div[DIV_BITS-1:0];
  assign w_cols     = ~r_sync2;
  assign w_scan_end = w_sample && (w_row == 2'd3);

  // Snapshot including the sample being taken this cycle
  always_comb begin
    w_snap = r_snap;
    if (w_sample) begin
      case (w_row)
        2'd0:    w_snap[3:0]   = w_cols;
        2'd1:    w_snap[7:4]   = w_cols;
        2'd2:    w_snap[11:8]  = w_cols;
        default: w_snap[15:12] = w_cols;
      endcase
    end
  end

  // Single pressed key yields its index; none or several yield NONE
  always_comb begin
    w_pop = '0;
    w_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_snap[i]) begin
        w_pop = w_pop + 5'd1;
        w_idx = 4'(i);
      end
    end
    w_cand = (w_pop == 5'd1) ? {1'b0, w_idx} : NONE;
  end

  always_comb begin
    if (w_cand == r_prev)
      w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;
    else
      w_cnt_nxt = 4'd1;
  end

  assign w_accept = w_scan_end && (w_cnt_nxt == CNT_MAX) && (w_cand != r_stable);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_sync1   <= 4'hF;
      r_sync2   <= 4'hF;
      r_snap    <= '0;
      r_prev    <= NONE;
      r_stable  <= NONE;
      r_cnt     <= '0;
      row_n     <= 4'hF;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      value     <= '0;
    end else begin
      r_div     <= r_div + DW'(1);
      r_sync1   <= col_n;
      r_sync2   <= r_sync1;
      r_snap    <= w_snap;
      row_n     <= ~(4'b0001 << w_row);
      key_valid <= w_accept && !w_cand[4];
      if (w_scan_end) begin
        r_prev <= w_cand;
        r_cnt  <= w_cnt_nxt;
      end
      if (w_accept) r_stable <= w_cand;
      if (w_accept && !w_cand[4]) begin
        key_code <= w_cand[3:0];
        key_down <= 1'b1;
        value    <= clear ? {12'h000, w_cand[3:0]} : {value[11:0], w_cand[3:0]};
      end else begin
        if (w_accept) key_down <= 1'b0;
        if (clear)    value    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_hex.sv
// Bench for keypad_hex: combinational keypad model plus a scan-level
// reference model of candidate selection, debounce, strobe and nibble entry.
module tb_keypad_hex;

  localparam int NONE_K = 16;
  localparam int DS     = 3;

  logic        mclk = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        clear;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] value;

  logic [15:0] pressed;

  int n_vec = 0;
  int n_err = 0;

  int          m_prev, m_run, m_stable;
  logic [3:0]  m_code;
  logic        m_down;
  logic [15:0] m_value;

  keypad_hex #(.DIV_BITS(2), .DEBOUNCE_SCANS(DS)) dut (
    .mclk(mclk), .reset(reset), .row_n(row_n), .col_n(col_n), .clear(clear),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .value(value)
  );

  always #5 mclk = ~mclk;

  // Key (r,c) pulls column c low while row r is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = NONE_K; m_run = 0; m_stable = NONE_K;
    m_code = '0; m_down = 1'b0; m_value = '0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge mclk); #1;
      check("rst_row_n", {12'h0, row_n}, 16'h000F);
      check("rst_valid", {15'h0, key_valid}, 16'h0);
      check("rst_code",  {12'h0, key_code}, 16'h0);
      check("rst_down",  {15'h0, key_down}, 16'h0);
      check("rst_value", value, 16'h0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // One full scan with a fixed key set; optional clear in the scan's final cycle
  task automatic scan(input logic [15:0] keys, input bit clr);
    int          pc, cand;
    bit          acc, exp_valid;
    logic [3:0]  er;
    pressed = keys;
    for (int k = 1; k <= 16; k++) begin
      @(posedge mclk); #1;
      clear = 1'b0;
      er = ~(4'b0001 << ((k - 1) / 4));
      check("row_n", {12'h0, row_n}, {12'h0, er});
      if (k < 16) begin
        check("no_strobe", {15'h0, key_valid}, 16'h0);
        check("value_hold", value, m_value);
      end
      if (k == 15 && clr) clear = 1'b1;
    end
    pc = 0; cand = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) begin pc++; cand = i; end
    if (pc != 1) cand = NONE_K;
    m_run  = (cand == m_prev) ? m_run + 1 : 1;
    m_prev = cand;
    acc = (m_run >= DS) && (cand != m_stable);
    exp_valid = 1'b0;
    if (acc) m_stable = cand;
    if (acc && cand != NONE_K) begin
      exp_valid = 1'b1;
      m_code    = 4'(cand);
      m_down    = 1'b1;
      m_value   = clr ? {12'h000, 4'(cand)} : {m_value[11:0], 4'(cand)};
    end else begin
      if (acc) m_down  = 1'b0;
      if (clr) m_value = '0;
    end
    check("key_valid", {15'h0, key_valid}, {15'h0, exp_valid});
    check("key_code",  {12'h0, key_code},  {12'h0, m_code});
    check("key_down",  {15'h0, key_down},  {15'h0, m_down});
    check("value",     value, m_value);
  endtask

  task automatic hold(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) scan(keys, 1'b0);
  endtask

  initial begin
    pressed = '0;
    clear   = 1'b0;
    model_reset();
    apply_reset(5);
    hold(16'h0000, 2);

    // Single key (2,1) held then released
    hold(16'h0001 << 9, 10);
    check("t2_code",  {12'h0, key_code}, 16'h0009);
    check("t2_value", value, 16'h0009);
    hold(16'h0000, 4);

    // Sequential entry of keys 1..5
    for (int k = 1; k <= 5; k++) begin
      hold(16'h0001 << k, 6);
      hold(16'h0000, 6);
    end
    check("t3_value", value, 16'h2345);
    check("t3_code",  {12'h0, key_code}, 16'h0005);

    // Bouncing key (0,0)
    for (int i = 0; i < 8; i++) scan((i % 2 == 0) ? 16'h0001 : 16'h0000, 1'b0);
    hold(16'h0000, 4);

    // Two keys, release one, slide to a neighbour
    hold(16'h8010, 6);
    hold(16'h0010, 5);
    hold(16'h0020, 5);
    hold(16'h0000, 4);

    // Randomized key sets and hold times
    for (int s = 0; s < 24; s++) begin
      int          r, h;
      logic [15:0] keys;
      r = int'($urandom_range(0, 9));
      if (r < 6)      keys = 16'h0001 << $urandom_range(0, 15);
      else if (r < 8) keys = 16'h0000;
      else            keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      h = int'($urandom_range(1, 5));
      for (int i = 0; i < h; i++) scan(keys, $urandom_range(0, 9) == 0);
    end
    hold(16'h0000, 4);

    // Clear coinciding with the accept of key F
    scan(16'h0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      hold(16'h0001 << k, 4);
      hold(16'h0000, 4);
    end
    check("t6_pre_value", value, 16'h1234);
    hold(16'h8000, 2);
    scan(16'h8000, 1'b1);
    check("t6_clr_value", value, 16'h000F);
    hold(16'h0000, 4);

    // Reset while key 7 is held, key stays held afterwards
    hold(16'h0080, 5);
    apply_reset(3);
    hold(16'h0080, 5);
    check("t6_rst_code",  {12'h0, key_code}, 16'h0007);
    check("t6_rst_value", value, 16'h0007);
    hold(16'h0000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
